// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI read issue path.
package apb2axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int DESC_LEN_W = 8;
  localparam int REM_W      = 9;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [DESC_LEN_W-1:0] len;
    logic [2:0]            size;
  } directory_entry_t;

  localparam int CMD_ENTRY_W = $bits(directory_entry_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } rd_split_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_ARCACHE_RD = 4'b0011;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/apb2axi_burst_calc.sv
// Combinational sizing of one INCR sub-burst: never crosses the split
// boundary and never exceeds 2^AXI_LEN_W beats.
module apb2axi_burst_calc
  import apb2axi_pkg::*;
#(
  parameter int AXI_LEN_W      = 8,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [REM_W-1:0]      remaining,
  input  logic [2:0]            size,
  output logic [AXI_LEN_W-1:0]  arlen,
  output logic [AXI_ADDR_W-1:0] next_addr,
  output logic [REM_W-1:0]      remaining_next
);

  localparam int BND_W = $clog2(BOUNDARY_BYTES);
  localparam logic [REM_W-1:0] MAX_BEATS = REM_W'(2 ** AXI_LEN_W);

  logic [AXI_ADDR_W-1:0] aligned_addr;
  logic [31:0]           to_bnd;
  logic [REM_W-1:0]      cap_beats;
  logic [REM_W-1:0]      beats;

  // beats = min(remaining, max burst, beats left before the boundary)
  always_comb begin
    // Sub-size address bits do not move the first beat, so drop them first.
    aligned_addr   = (addr >> size) << size;
    to_bnd         = (32'(BOUNDARY_BYTES) - 32'(aligned_addr[BND_W-1:0])) >> size;
    cap_beats      = (to_bnd > 32'(MAX_BEATS)) ? MAX_BEATS : to_bnd[REM_W-1:0];
    beats          = (remaining < cap_beats) ? remaining : cap_beats;
    arlen          = AXI_LEN_W'(beats - REM_W'(1));
    next_addr      = aligned_addr + (AXI_ADDR_W'(beats) << size);
    remaining_next = remaining - beats;
  end

endmodule

// File: rtl/apb2axi_rd_burst_splitter.sv
// AR issue engine: pops read descriptors, splits them into legal INCR
// sub-bursts and issues them under an outstanding-AR credit limit.
// Optional statistics counters: define APB2AXI_RD_SPLIT_STATS_EN.
//
// state | meaning
// IDLE  | ready to pop the next descriptor
// CALC  | size the next sub-burst into the AR registers
// ISSUE | present AR; arvalid only while a credit is free
module apb2axi_rd_burst_splitter
  import apb2axi_pkg::*;
#(
  parameter int FIFO_ENTRY_W    = CMD_ENTRY_W,
  parameter int AXI_LEN_W       = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BOUNDARY_BYTES  = 4096
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic [AXI_ID_W-1:0]     arid,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [AXI_LEN_W-1:0]    arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic                    rd_pop_vld,
  input  logic [FIFO_ENTRY_W-1:0] rd_pop_data,
  output logic                    rd_pop_rdy,
  input  logic                    r_done,
  output logic                    split_last,
  output logic                    busy,
  output logic [31:0]             stat_desc_cnt,
  output logic [31:0]             stat_ar_cnt,
  output logic [31:0]             stat_split_cnt,
  output logic [31:0]             stat_credit_stall
);

  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  rd_split_state_e       state_q, state_d;
  logic [AXI_ID_W-1:0]   arid_q, arid_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d, araddr_q, araddr_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
  logic                  split_last_q, split_last_d;
  logic [7:0]            outstanding_q, outstanding_d;

  directory_entry_t      pop_desc;
  logic                  pop, ar_hs, credit_ok, ret;
  logic [AXI_LEN_W-1:0]  calc_arlen;
  logic [AXI_ADDR_W-1:0] calc_next_addr;
  logic [REM_W-1:0]      calc_rem_next;

  assign pop_desc   = directory_entry_t'(rd_pop_data[CMD_ENTRY_W-1:0]);
  // Held low while reset is applied even though the state is already IDLE.
  assign rd_pop_rdy = aresetn && (state_q == IDLE);
  assign pop        = rd_pop_vld && rd_pop_rdy;
  assign credit_ok  = outstanding_q < MAX_OUT;
  assign arvalid    = (state_q == ISSUE) && credit_ok;
  assign ar_hs      = arvalid && arready;
  assign ret        = r_done && (outstanding_q != 8'd0);

  assign arid       = arid_q;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;
  assign arsize     = arsize_q;
  assign split_last = split_last_q;
  assign arburst    = AXI_BURST_INCR;
  assign arlock     = 1'b0;
  assign arcache    = AXI_ARCACHE_RD;
  assign arprot     = 3'b000;
  assign busy       = (state_q != IDLE) || (outstanding_q != 8'd0);

  apb2axi_burst_calc #(
    .AXI_LEN_W     (AXI_LEN_W),
    .BOUNDARY_BYTES(BOUNDARY_BYTES)
  ) u_calc (
    .addr          (addr_q),
    .remaining     (rem_q),
    .size          (arsize_q),
    .arlen         (calc_arlen),
    .next_addr     (calc_next_addr),
    .remaining_next(calc_rem_next)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = CALC;
      CALC:    state_d = ISSUE;
      ISSUE:   if (ar_hs) state_d = (rem_q == '0) ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  // Descriptor capture and sub-burst registers; AR fields only change in CALC
  always_comb begin
    arid_d       = arid_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    arsize_d     = arsize_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    split_last_d = split_last_q;
    if (pop) begin
      arid_d   = pop_desc.tag;
      addr_d   = pop_desc.addr;
      rem_d    = REM_W'(pop_desc.len) + REM_W'(1);
      arsize_d = pop_desc.size;
    end
    if (state_q == CALC) begin
      araddr_d     = addr_q;
      arlen_d      = calc_arlen;
      split_last_d = (calc_rem_next == '0);
      addr_d       = calc_next_addr;
      rem_d        = calc_rem_next;
    end
  end

  // Outstanding AR credit count; a return with nothing outstanding is dropped
  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs && !ret)      outstanding_d = outstanding_q + 8'd1;
    else if (ret && !ar_hs) outstanding_d = outstanding_q - 8'd1;
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath and credit registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arid_q        <= '0;
      addr_q        <= '0;
      rem_q         <= '0;
      arsize_q      <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      split_last_q  <= 1'b0;
      outstanding_q <= '0;
    end else begin
      arid_q        <= arid_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      arsize_q      <= arsize_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      split_last_q  <= split_last_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifndef SYNTHESIS
  a_no_spurious_done: assert property (@(posedge aclk) disable iff (!aresetn)
    !(r_done && (outstanding_q == 8'd0)));
`endif

`ifdef APB2AXI_RD_SPLIT_STATS_EN
  logic [31:0] desc_cnt_q, desc_cnt_d, ar_cnt_q, ar_cnt_d;
  logic [31:0] split_cnt_q, split_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        first_q, first_d;

  // Saturating event counters; a split is detected when the first CALC leaves beats over
  always_comb begin
    first_d     = pop ? 1'b1 : ((state_q == CALC) ? 1'b0 : first_q);
    desc_cnt_d  = sat_inc(desc_cnt_q, pop);
    ar_cnt_d    = sat_inc(ar_cnt_q, ar_hs);
    split_cnt_d = sat_inc(split_cnt_q, (state_q == CALC) && first_q && (calc_rem_next != '0));
    stall_cnt_d = sat_inc(stall_cnt_q, (state_q == ISSUE) && !credit_ok);
  end

  // Statistics registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_q     <= 1'b0;
      desc_cnt_q  <= '0;
      ar_cnt_q    <= '0;
      split_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      first_q     <= first_d;
      desc_cnt_q  <= desc_cnt_d;
      ar_cnt_q    <= ar_cnt_d;
      split_cnt_q <= split_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_desc_cnt     = desc_cnt_q;
  assign stat_ar_cnt       = ar_cnt_q;
  assign stat_split_cnt    = split_cnt_q;
  assign stat_credit_stall = stall_cnt_q;
`else
  assign stat_desc_cnt     = '0;
  assign stat_ar_cnt       = '0;
  assign stat_split_cnt    = '0;
  assign stat_credit_stall = '0;
`endif

endmodule

// File: tb/tb_apb2axi_rd_burst_splitter.sv
// Directed and randomized bench for apb2axi_rd_burst_splitter
// (AXI_LEN_W=4, MAX_OUTSTANDING=2, 4KB boundary).
module tb_apb2axi_rd_burst_splitter;
  import apb2axi_pkg::*;

  localparam int LEN_W   = 4;
  localparam int MAX_OUT = 2;
  localparam int BND     = 4096;
  localparam int NRND    = 30;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
    logic [2:0]            size;
    logic                  last;
  } ar_t;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic [AXI_ID_W-1:0]    arid;
  logic [AXI_ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]       arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arlock;
  logic [3:0]             arcache;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready = 1'b0;
  logic                   rd_pop_vld = 1'b0;
  logic [CMD_ENTRY_W-1:0] rd_pop_data = '0;
  logic                   rd_pop_rdy;
  logic                   r_done = 1'b0;
  logic                   split_last;
  logic                   busy;
  logic [31:0]            stat_desc_cnt, stat_ar_cnt, stat_split_cnt, stat_credit_stall;

  always #5 aclk = ~aclk;

  apb2axi_rd_burst_splitter #(
    .AXI_LEN_W      (LEN_W),
    .MAX_OUTSTANDING(MAX_OUT),
    .BOUNDARY_BYTES (BND)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rd_pop_vld(rd_pop_vld), .rd_pop_data(rd_pop_data), .rd_pop_rdy(rd_pop_rdy),
    .r_done(r_done), .split_last(split_last), .busy(busy),
    .stat_desc_cnt(stat_desc_cnt), .stat_ar_cnt(stat_ar_cnt),
    .stat_split_cnt(stat_split_cnt), .stat_credit_stall(stat_credit_stall)
  );

  int  checks = 0;
  int  failures = 0;
  ar_t obs_q[$];
  ar_t exp_q[$];
  int  pop_cnt = 0;
  int  mo = 0;
  logic hold_prev = 1'b0;
  ar_t  hold_ar;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic ar_t cur_ar();
    ar_t a;
    a.id = arid; a.addr = araddr; a.len = arlen; a.size = arsize; a.last = split_last;
    return a;
  endfunction

  function automatic directory_entry_t mk(input logic [AXI_ID_W-1:0] t, input logic [31:0] a,
                                          input int l, input int s);
    directory_entry_t d;
    d.tag = t; d.addr = a; d.len = 8'(l); d.size = 3'(s);
    return d;
  endfunction

  // Expected AR list for one descriptor, straight from the splitting rules.
  function automatic int model_desc(input directory_entry_t d);
    logic [AXI_ADDR_W-1:0] a, al;
    int rem, off, to_bnd, beats, n;
    ar_t e;
    a = d.addr; rem = int'(d.len) + 1; n = 0;
    while (rem > 0) begin
      al = (a >> d.size) << d.size;
      off = int'(al % AXI_ADDR_W'(BND));
      to_bnd = (BND - off) >> d.size;
      beats = rem;
      if (beats > (1 << LEN_W)) beats = 1 << LEN_W;
      if (beats > to_bnd) beats = to_bnd;
      e.id = d.tag; e.addr = (n == 0) ? a : al; e.len = LEN_W'(beats - 1);
      e.size = d.size; e.last = (rem == beats);
      exp_q.push_back(e);
      a = al + AXI_ADDR_W'(beats << d.size);
      rem -= beats; n++;
    end
    return n;
  endfunction

  // Monitor: records AR handshakes and pops, tracks outstanding, checks AR stability.
  always @(negedge aclk) begin
    if (!aresetn) begin
      mo = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", arvalid, 1'b1);
        chk("hold_fields", cur_ar(), hold_ar);
      end
      if (arvalid) chk("credit_limit", (mo < MAX_OUT), 1'b1);
      if (arvalid && arready) obs_q.push_back(cur_ar());
      if (rd_pop_vld && rd_pop_rdy) pop_cnt++;
      mo = mo + ((arvalid && arready) ? 1 : 0) - ((r_done && mo > 0) ? 1 : 0);
      hold_prev = arvalid && !arready;
      hold_ar = cur_ar();
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_pop(input directory_entry_t d);
    int p0, k;
    p0 = pop_cnt; k = 0;
    rd_pop_vld = 1'b1; rd_pop_data = d;
    do begin cyc(); k++; end while (pop_cnt == p0 && k < 100);
    rd_pop_vld = 1'b0;
    chk("pop_once", pop_cnt, p0 + 1);
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 500) begin cyc(); k++; end
    chk("ar_count", obs_q.size(), n);
  endtask

  task automatic drain();
    int k = 0;
    while ((mo > 0 || busy) && k < 2000) begin
      r_done = (mo > 0);
      cyc(); k++;
    end
    r_done = 1'b0;
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_n"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_ar"}, obs_q[i], exp_q[i]);
  endtask

  task automatic clr();
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    directory_entry_t d, descs[NRND];
    ar_t snap;
    int p0, n, k, nsplit;
    logic [31:0] ra;

    repeat (3) cyc();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_pop_rdy", rd_pop_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_split_last", split_last, 1'b0);
    chk("rst_fields", {arid, araddr, arlen, arsize}, '0);
    aresetn = 1'b1;
    cyc();
    chk("idle_pop_rdy", rd_pop_rdy, 1'b1);

    // Single in-boundary descriptor with latency check
    clr(); arready = 1'b1;
    d = mk(4'h1, 32'h100, 7, 2);
    n = model_desc(d);
    push_pop(d);
    chk("t1_calc_arvalid", arvalid, 1'b0);
    cyc();
    chk("t1_lat_arvalid", arvalid, 1'b1);
    chk("t1_fields", cur_ar(), exp_q[0]);
    cyc();
    chk("t1_arvalid_after", arvalid, 1'b0);
    drain();
    cmp_all("t1");

    // 4KB crossing
    clr();
    d = mk(4'h2, 32'h0FF0, 15, 2);
    n = model_desc(d);
    p0 = pop_cnt;
    push_pop(d);
    wait_obs(n);
    drain();
    cmp_all("t2");
    chk("t2_pops", pop_cnt - p0, 1);

    // Length split at 16 beats
    clr();
    d = mk(4'h3, 32'h0, 31, 3);
    n = model_desc(d);
    p0 = pop_cnt;
    push_pop(d);
    wait_obs(n);
    repeat (3) cyc();
    drain();
    cmp_all("t3");
    chk("t3_pops", pop_cnt - p0, 1);

    // Backpressure
    clr(); arready = 1'b0;
    d = mk(4'h4, 32'h2000, 3, 2);
    n = model_desc(d);
    push_pop(d);
    k = 0;
    while (!arvalid && k < 50) begin cyc(); k++; end
    chk("bp_arvalid", arvalid, 1'b1);
    snap = cur_ar();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid_held", arvalid, 1'b1);
      chk("bp_fields_held", cur_ar(), snap);
    end
    chk("bp_no_hs", obs_q.size(), 0);
    arready = 1'b1;
    cyc();
    chk("bp_one_hs", obs_q.size(), 1);
    drain();
    cmp_all("t4");

    // Credit limit
    clr(); arready = 1'b1;
    d = mk(4'h5, 32'h3000, 1, 2); n = model_desc(d); push_pop(d);
    d = mk(4'h6, 32'h3100, 1, 2); n = model_desc(d); push_pop(d);
    d = mk(4'h7, 32'h3200, 1, 2); n = model_desc(d); push_pop(d);
    repeat (4) cyc();
    chk("cr_held_arvalid", arvalid, 1'b0);
    chk("cr_two_issued", obs_q.size(), 2);
    chk("cr_busy", busy, 1'b1);
    r_done = 1'b1;
    cyc();
    r_done = 1'b0;
    chk("cr_release_arvalid", arvalid, 1'b1);
    r_done = 1'b1;
    cyc();
    r_done = 1'b0;
    chk("cr_third_issued", obs_q.size(), 3);
    d = mk(4'h8, 32'h3300, 1, 2); n = model_desc(d); push_pop(d);
    wait_obs(4);
    d = mk(4'h9, 32'h3400, 1, 2); n = model_desc(d); push_pop(d);
    repeat (4) cyc();
    chk("cr_count_kept_arvalid", arvalid, 1'b0);
    chk("cr_count_kept_n", obs_q.size(), 4);
    drain();
    cmp_all("t5");

    // Async reset between sub-bursts
    clr(); arready = 1'b1;
    d = mk(4'hA, 32'h4FF0, 15, 2);
    n = model_desc(d);
    push_pop(d);
    p0 = pop_cnt;
    wait_obs(1);
    arready = 1'b0;
    k = 0;
    while (!arvalid && k < 20) begin cyc(); k++; end
    chk("rs_ar1_pending", arvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    chk("rs_arvalid_async", arvalid, 1'b0);
    chk("rs_busy_async", busy, 1'b0);
    chk("rs_pop_rdy_async", rd_pop_rdy, 1'b0);
    cyc(); cyc();
    aresetn = 1'b1; arready = 1'b1;
    repeat (10) cyc();
    chk("rs_no_more_ar", obs_q.size(), 1);
    chk("rs_busy_after", busy, 1'b0);
    chk("rs_no_repop", pop_cnt, p0);
    chk("rs_ar0", obs_q[0], exp_q[0]);

    // Randomized descriptors with random AR backpressure and completions
    clr(); nsplit = 0;
    for (int i = 0; i < NRND; i++) begin
      ra = $urandom;
      if ($urandom_range(1) == 1) ra[11:8] = 4'hF;
      descs[i] = mk(4'($urandom), ra, int'($urandom_range(255)), int'($urandom_range(3)));
      n = model_desc(descs[i]);
      if (n > 1) nsplit++;
    end
    p0 = pop_cnt; k = 0;
    while (((pop_cnt - p0) < NRND || obs_q.size() < exp_q.size()) && k < 30000) begin
      rd_pop_vld = ((pop_cnt - p0) < NRND);
      if (rd_pop_vld) rd_pop_data = descs[pop_cnt - p0];
      arready = ($urandom_range(3) != 0);
      r_done = (mo > 0) && ($urandom_range(2) == 0);
      cyc(); k++;
    end
    rd_pop_vld = 1'b0; r_done = 1'b0; arready = 1'b1;
    chk("rnd_in_budget", (k < 30000), 1'b1);
    drain();
    chk("rnd_pops", pop_cnt - p0, NRND);
    cmp_all("rnd");
`ifdef APB2AXI_RD_SPLIT_STATS_EN
    chk("stat_desc", stat_desc_cnt, NRND);
    chk("stat_ar", stat_ar_cnt, exp_q.size());
    chk("stat_split", stat_split_cnt, nsplit);
    $display("info credit stall cycles=%0d", stat_credit_stall);
`else
    chk("stat_desc_tied", stat_desc_cnt, 0);
    chk("stat_ar_tied", stat_ar_cnt, 0);
    chk("stat_split_tied", stat_split_cnt, 0);
    chk("stat_stall_tied", stat_credit_stall, 0);
`endif
    chk("const_ar_attrs", {arburst, arlock, arcache, arprot}, {2'b01, 1'b0, 4'b0011, 3'b000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
